// File: rtl/loco_pkg.sv
// Shared constants and state encodings for the LOCO-I Golomb-Rice code path.
package loco_pkg;

  localparam int QBPP  = 8;
  localparam int LIMIT = 32;
  localparam int ESC_Q = LIMIT - QBPP - 1;
  localparam int KW    = 4;
  localparam int VW    = 16;
  localparam int BUF_W = 32;
  localparam int CNT_W = 6;
  localparam int QW    = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_UNARY = 3'd1,
    ST_REM   = 3'd2,
    ST_ESC   = 3'd3,
    ST_OUT   = 3'd4
  } gr_state_e;

endpackage

// File: rtl/loco_gr_unpacker_if.sv
// Byte-stream and symbol-request bundle between the unpacker and its neighbours.
interface loco_gr_unpacker_if;
  import loco_pkg::*;

  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          sym_req;
  logic [KW-1:0] k;
  logic          req_ready;
  logic          sym_valid;
  logic [VW-1:0] sym_val;
  logic          sym_esc;
  logic          flush;
  logic          err;

  modport master (
    output byte_in, byte_valid, sym_req, k, flush,
    input  byte_ready, req_ready, sym_valid, sym_val, sym_esc, err
  );

  modport slave (
    input  byte_in, byte_valid, sym_req, k, flush,
    output byte_ready, req_ready, sym_valid, sym_val, sym_esc, err
  );

endinterface

// File: rtl/loco_bitbuf.sv
// MSB-first refill/consume shift buffer: bytes enter below the valid bits,
// consumers take 0..8 bits per cycle from the top.
module loco_bitbuf
  import loco_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  input  logic [3:0]       consume_i,
  output logic [7:0]       peek_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q;
  logic [BUF_W-1:0] shifted;
  logic [CNT_W-1:0] cnt_sh;

  assign byte_ready_o = en_q && (cnt_q <= CNT_W'(24)) && !flush_i;
  assign peek_o       = buf_q[BUF_W-1 -: 8];
  assign cnt_o        = cnt_q;

  // Bits below cnt are kept zero so the new byte can simply be OR-ed in.
  always_comb begin
    shifted = buf_q << consume_i;
    cnt_sh  = cnt_q - CNT_W'(consume_i);
    buf_d   = shifted;
    cnt_d   = cnt_sh;
    if (byte_valid_i && byte_ready_o) begin
      buf_d = shifted | ({byte_i, 24'h000000} >> cnt_sh);
      cnt_d = cnt_sh + CNT_W'(8);
    end
    if (flush_i) begin
      buf_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      en_q  <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      en_q  <= 1'b1;
    end
  end

endmodule

// File: rtl/loco_gr_unpacker.sv
// Limited-length Golomb-Rice decoder with JPEG-LS escape, one symbol per request.
//   state    | meaning
//   ST_IDLE  | waiting for sym_req, k latched on accept
//   ST_UNARY | counting leading zeros, one bit per cycle
//   ST_REM   | taking k remainder bits, assembling (q << k) | r
//   ST_ESC   | taking QBPP payload bits, value = payload + 1
//   ST_OUT   | one-cycle sym_valid pulse
module loco_gr_unpacker
  import loco_pkg::*;
(
  input logic               clk,
  input logic               rst,
  loco_gr_unpacker_if.slave bus
);

  gr_state_e        state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [QW-1:0]    q_q, q_d;
  logic [VW-1:0]    val_q, val_d;
  logic             esc_q, esc_d;
  logic             valid_q, valid_d;
  logic             rdy_q, rdy_d;
  logic             err_q, err_d;

  logic [7:0]       peek;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       consume;
  logic [7:0]       rbits;
  logic [VW-1:0]    val_rem;
  logic [VW-1:0]    val_esc;
  logic             rem_ok;
  logic             esc_ok;

  loco_bitbuf u_buf (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (bus.flush),
    .byte_i       (bus.byte_in),
    .byte_valid_i (bus.byte_valid),
    .byte_ready_o (bus.byte_ready),
    .consume_i    (consume),
    .peek_o       (peek),
    .cnt_o        (cnt)
  );

  assign rem_ok  = (cnt >= CNT_W'(k_q));
  assign esc_ok  = (cnt >= CNT_W'(QBPP));
  // A shift of 8 (k = 0) empties the byte, giving r = 0.
  assign rbits   = peek >> (4'd8 - 4'(k_q));
  assign val_rem = (VW'(q_q) << k_q) | VW'(rbits);
  assign val_esc = VW'(peek) + VW'(1);

  always_comb begin
    consume = 4'd0;
    unique case (state_q)
      ST_UNARY: if (cnt != '0) consume = 4'd1;
      ST_REM:   if (rem_ok) consume = 4'(k_q);
      ST_ESC:   if (esc_ok) consume = 4'(QBPP);
      default:  consume = 4'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    q_d     = q_q;
    val_d   = val_q;
    esc_d   = esc_q;
    err_d   = err_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      q_d     = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.sym_req && rdy_q) begin
            k_d = bus.k;
            q_d = '0;
            if (bus.k >= KW'(QBPP)) begin
              err_d   = 1'b1;
              val_d   = '0;
              esc_d   = 1'b0;
              state_d = ST_OUT;
            end else begin
              state_d = ST_UNARY;
            end
          end
        end
        ST_UNARY: begin
          // A zero arriving at the threshold is taken as the escape terminator.
          if (cnt != '0) begin
            if (q_q == QW'(ESC_Q))  state_d = ST_ESC;
            else if (peek[7])       state_d = ST_REM;
            else                    q_d = q_q + QW'(1);
          end
        end
        ST_REM: begin
          if (rem_ok) begin
            val_d   = val_rem;
            esc_d   = 1'b0;
            state_d = ST_OUT;
          end
        end
        ST_ESC: begin
          if (esc_ok) begin
            val_d   = val_esc;
            esc_d   = 1'b1;
            state_d = ST_OUT;
          end
        end
        ST_OUT:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    valid_d = (state_d == ST_OUT);
    rdy_d   = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      q_q     <= '0;
      val_q   <= '0;
      esc_q   <= 1'b0;
      valid_q <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      q_q     <= q_d;
      val_q   <= val_d;
      esc_q   <= esc_d;
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.sym_valid = valid_q;
  assign bus.sym_val   = val_q;
  assign bus.sym_esc   = esc_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_loco_gr_unpacker.sv
// Bench for loco_gr_unpacker: directed vector table, corner sequences and a
// random encoded stream decoded against the generator's own symbol list.
module tb_loco_gr_unpacker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] feed_q[$];
  int         bytes_taken = 0;
  bit         bp_seen = 1'b0;

  loco_gr_unpacker_if bus();

  loco_gr_unpacker dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bytes;
    int          nb;
    int          k;
    int          val;
    int          esc;
    int          lat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Byte source: presents the queue head, pops it when the DUT accepted it.
  initial begin
    logic acc;
    forever begin
      @(negedge clk);
      bus.byte_valid = (feed_q.size() > 0);
      bus.byte_in    = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
      #1;
      acc = bus.byte_valid && bus.byte_ready;
      if (bus.byte_valid && !bus.byte_ready && !bus.flush && !rst) bp_seen = 1'b1;
      @(posedge clk);
      if (acc && feed_q.size() > 0) begin
        void'(feed_q.pop_front());
        bytes_taken++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_flush();
    bus.flush = 1'b1;
    feed_q.delete();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  task automatic start_req(input int kk);
    int w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_wait", bus.req_ready, 1);
    bus.sym_req = 1'b1;
    bus.k       = 4'(kk);
  endtask

  task automatic wait_valid(output int val, output int esc, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      bus.sym_req = 1'b0;
      lat++;
    end while (!bus.sym_valid && lat < 200);
    chk("sym_valid_seen", bus.sym_valid, 1);
    val = bus.sym_val;
    esc = bus.sym_esc;
  endtask

  initial begin
    int v, e, l, nv;
    bit bq[$];
    int exp_v[$], exp_e[$], exp_k[$];
    int nbytes, used;
    int k0_exp [4];

    vecs[0] = '{32'h2800_0000, 1, 2,    9, 0,  5};
    vecs[1] = '{32'h8000_0000, 1, 0,    0, 0,  3};
    vecs[2] = '{32'h0000_014F, 4, 3,   80, 1, 26};
    vecs[3] = '{32'h0000_03FC, 4, 7, 2943, 0, 25};
    vecs[4] = '{32'h0000_00AB, 4, 2,  172, 1, 26};
    vecs[5] = '{32'h6C00_0000, 1, 5,   54, 0,  4};
    vecs[6] = '{32'h00C0_0000, 2, 1,   17, 0, 11};
    vecs[7] = '{32'hF800_0000, 1, 4,   15, 0,  3};
    k0_exp  = '{1, 1, 0, 1};

    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.sym_req = 1'b0;
    bus.k = '0; bus.flush = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_byte_ready", bus.byte_ready, 0);
    chk("rst_req_ready",  bus.req_ready, 0);
    chk("rst_sym_valid",  bus.sym_valid, 0);
    chk("rst_sym_val",    bus.sym_val, 0);
    chk("rst_sym_esc",    bus.sym_esc, 0);
    chk("rst_err",        bus.err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", bus.req_ready, 1);
    chk("post_rst_cnt", dut.u_buf.cnt_q, 0);

    for (int i = 0; i < 8; i++) begin
      do_flush();
      for (int j = 0; j < vecs[i].nb; j++) feed_q.push_back(8'(vecs[i].bytes >> (24 - 8 * j)));
      repeat (8) @(negedge clk);
      start_req(vecs[i].k);
      wait_valid(v, e, l);
      chk($sformatf("vec%0d_val", i), v, vecs[i].val);
      chk($sformatf("vec%0d_esc", i), e, vecs[i].esc);
      chk($sformatf("vec%0d_lat", i), l, vecs[i].lat);
    end

    // k = 0 run over 0101_1010
    do_flush();
    feed_q.push_back(8'h5A);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      start_req(0);
      wait_valid(v, e, l);
      chk($sformatf("k0_run%0d_val", i), v, k0_exp[i]);
    end
    @(negedge clk);
    chk("k0_run_cnt", dut.u_buf.cnt_q, 1);

    // starved input: 0001_1111 arrives late, q=3 r=1111
    do_flush();
    start_req(4);
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.sym_req = 1'b0;
      if (bus.sym_valid) nv++;
    end
    chk("starve_no_valid", nv, 0);
    feed_q.push_back(8'h1F);
    wait_valid(v, e, l);
    chk("starve_val", v, 63);
    chk("starve_esc", e, 0);

    // illegal k: error, zero value, no bits taken; err stays set
    do_flush();
    feed_q.push_back(8'h80);
    repeat (4) @(negedge clk);
    chk("err_cnt_before", dut.u_buf.cnt_q, 8);
    start_req(9);
    wait_valid(v, e, l);
    chk("err_val", v, 0);
    chk("err_lat", l, 1);
    chk("err_flag", bus.err, 1);
    chk("err_cnt_after", dut.u_buf.cnt_q, 8);
    start_req(0);
    wait_valid(v, e, l);
    chk("err_next_val", v, 0);
    chk("err_sticky", bus.err, 1);

    // flush in the middle of a long unary run
    feed_q.push_back(8'h00);
    feed_q.push_back(8'h00);
    repeat (4) @(negedge clk);
    start_req(2);
    @(negedge clk);
    bus.sym_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("unary_busy", bus.req_ready, 0);
    bus.flush = 1'b1;
    feed_q.delete();
    #1;
    chk("flush_byte_ready", bus.byte_ready, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_cnt", dut.u_buf.cnt_q, 0);
    chk("flush_err", bus.err, 0);
    chk("flush_req_ready", bus.req_ready, 1);
    chk("flush_sym_valid", bus.sym_valid, 0);

    // random stream with continuous byte_valid
    do_flush();
    bytes_taken = 0;
    bp_seen = 1'b0;
    for (int s = 0; s < 1000; s++) begin
      int kk, val, q;
      bit esc;
      kk  = $urandom_range(0, 7);
      esc = ($urandom_range(0, 7) == 0);
      if (esc) begin
        val = $urandom_range(1, 256);
        for (int b = 0; b < 23; b++) bq.push_back(1'b0);
        bq.push_back(1'b1);
        for (int b = 7; b >= 0; b--) bq.push_back(1'(((val - 1) >> b) & 1));
      end else begin
        val = $urandom_range(0, (23 << kk) - 1);
        q   = val >> kk;
        for (int b = 0; b < q; b++) bq.push_back(1'b0);
        bq.push_back(1'b1);
        for (int b = kk - 1; b >= 0; b--) bq.push_back(1'((val >> b) & 1));
      end
      exp_v.push_back(val);
      exp_e.push_back(int'(esc));
      exp_k.push_back(kk);
    end
    used = bq.size();
    while (bq.size() % 8 != 0) bq.push_back(1'b0);
    nbytes = bq.size() / 8;
    for (int i = 0; i < nbytes; i++) begin
      logic [7:0] by;
      for (int b = 0; b < 8; b++) by[7 - b] = bq[8 * i + b];
      feed_q.push_back(by);
    end
    for (int s = 0; s < 1000; s++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_req(exp_k[s]);
      wait_valid(v, e, l);
      chk($sformatf("rnd%0d_val", s), v, exp_v[s]);
      chk($sformatf("rnd%0d_esc", s), e, exp_e[s]);
    end
    repeat (10) @(negedge clk);
    chk("rnd_bytes_taken", bytes_taken, nbytes);
    chk("rnd_cnt_left", dut.u_buf.cnt_q, nbytes * 8 - used);
    chk("rnd_backpressure", bp_seen, 1);

    // reset while stalled in the remainder phase (0100_0000, k=7)
    do_flush();
    feed_q.push_back(8'h40);
    repeat (4) @(negedge clk);
    start_req(7);
    @(negedge clk);
    bus.sym_req = 1'b0;
    repeat (5) @(negedge clk);
    chk("rem_stall_cnt", dut.u_buf.cnt_q, 6);
    rst = 1'b1;
    feed_q.delete();
    #1;
    chk("midrst_byte_ready", bus.byte_ready, 0);
    chk("midrst_req_ready",  bus.req_ready, 0);
    chk("midrst_sym_valid",  bus.sym_valid, 0);
    chk("midrst_sym_val",    bus.sym_val, 0);
    chk("midrst_sym_esc",    bus.sym_esc, 0);
    chk("midrst_err",        bus.err, 0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.sym_valid) nv++;
    end
    chk("midrst_no_valid", nv, 0);
    chk("midrst_cnt", dut.u_buf.cnt_q, 0);
    chk("midrst_idle", bus.req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
